godai_mem_arbiter: RTL

- Shares one single-ported memory between the core's instruction-fetch and data load/store interfaces.
- Both requester sides and the memory side use the core's req/gnt/rvalid protocol.
- Arbitration is round-robin. Each requester's request is held stable until it is granted.
- Responses are routed back in order through an outstanding-transaction ID FIFO.
- Sits between the core wrapper and a unified RAM or bus bridge.

---
 rtl/godai_mem_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/godai_mem_arbiter.sv
// godai_mem_arbiter: round-robin sharing of one req/gnt/rvalid memory port between
// instruction fetch and data load/store, with in-order response routing.
module godai_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  protocol_err_o
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    // Owner FIFO and select encoding: 1 = data port, 0 = instruction port.
    logic [MAX_OUTSTANDING-1:0] owner;
    logic [PW-1:0]              wptr, rptr, wptr_n, rptr_n;
    logic [CW-1:0]              count;
    logic last_grant, locked, locked_sel, sel, full, gnt, pop;

    assign full      = count == CW'(MAX_OUTSTANDING);
    assign mem_req_o = !full & (locked | instr_req_i | data_req_i);

    always_comb begin
        sel = locked ? locked_sel : (instr_req_i & data_req_i) ? !last_grant : data_req_i;
    end

    assign mem_we_o    = sel & data_we_i;
    assign mem_be_o    = sel ? data_be_i : 4'hF;
    assign mem_addr_o  = sel ? data_addr_i : instr_addr_i;
    assign mem_wdata_o = sel ? data_wdata_i : '0;

    assign gnt         = mem_gnt_i & mem_req_o;
    assign instr_gnt_o = gnt & !sel;
    assign data_gnt_o  = gnt & sel;

    assign pop            = mem_rvalid_i & (count != '0);
    assign instr_rvalid_o = pop & !owner[rptr];
    assign data_rvalid_o  = pop & owner[rptr];
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign data_err_o     = mem_err_i & data_rvalid_o;

    assign wptr_n = (wptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr + PW'(1);
    assign rptr_n = (rptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner          <= '0;
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            last_grant     <= 1'b1;
            locked         <= 1'b0;
            locked_sel     <= 1'b0;
            protocol_err_o <= 1'b0;
        end else begin
            if (gnt) begin
                owner[wptr] <= sel;
                wptr        <= wptr_n;
                last_grant  <= sel;
            end
            if (pop)
                rptr <= rptr_n;
            count <= count + CW'(gnt) - CW'(pop);
            // A stalled request pins the selection so the memory sees stable address/data.
            if (mem_req_o & !mem_gnt_i) begin
                locked     <= 1'b1;
                locked_sel <= sel;
            end else if (gnt) begin
                locked <= 1'b0;
            end
            protocol_err_o <= protocol_err_o | (mem_rvalid_i & (count == '0));
        end
    end
endmodule
